dm_latency: RTL and testbench
=============================

Name: dm_latency

Overview:
- Parametrised data memory for the MIPS datapath, successor of the single-cycle word/half/byte memory.
- Adds the following over the single-cycle memory:
  - configurable depth, base address and access latency;
  - valid/ready request handshake with a one-cycle response pulse;
  - sign/zero-extended sub-word loads, with merged sub-word stores done inside the block;
  - alignment and range exception reporting;
  - post-reset clearing sweep.
- Sits between the MEM stage and the pipeline stall logic. The stall unit holds the stage while `ready`=0.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words (DEPTH = 2**DEPTH_LOG2).
- BASE, 32'h0000_0000, byte address of word 0.
- LATENCY, 1, edges from acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load; sampled with req.
- op  input  3  access type: 000 W, 001 HU, 010 H (signed), 011 BU, 100 B (signed); 101-111 illegal.
- addr  input  32  byte address.
- wd  input  32  store data; low bits are used for sub-word stores.
- pc  input  32  PC of the requesting instruction, used for the store log.
- ready  output  1  block can accept a request this cycle.
- rvalid  output  1  one-cycle response pulse.
- rd  output  32  extended load data; valid while rvalid=1.
- exc  output  1  access fault; valid while rvalid=1.

Behaviour:
- Reset (async):
  - Outputs go to ready=0, rvalid=0, rd=0, exc=0.
  - FSM goes to INIT with sweep index 0.
  - Any in-flight request is discarded, including an uncommitted store.
- INIT:
  - One word per rising edge: mem[idx]<=0, idx++.
  - After DEPTH edges, go to IDLE.
  - ready=0 throughout.
  - req is ignored.
- IDLE:
  - ready=1.
  - On an edge with req=1:
    - latch we/op/addr/wd/pc;
    - load the counter with LATENCY-1;
    - go to BUSY if LATENCY>1, otherwise commit directly (see Commit).
- BUSY:
  - ready=0.
  - Counter decrements each edge.
  - On the edge where the counter is 0, commit.
- Commit edge (edge E+LATENCY, where E is the accept edge):
  - rvalid<=1 for exactly one cycle.
  - ready<=1 in that same cycle, so the next accept is possible at edge E+LATENCY+1.
  - Maximum throughput is one request per LATENCY+1 cycles.
- Fault check at commit. A fault is any of:
  - op illegal;
  - W with addr[1:0]≠0;
  - H/HU with addr[0]≠0;
  - addr<BASE or addr≥BASE+4·DEPTH.
- On a fault: exc=1, rd=0, no memory write, no log line.
- Load, no fault:
  - Word index = (addr-BASE)[DEPTH_LOG2+1:2].
  - W returns the whole word.
  - H/HU select half addr[1] (0 = bits 15:0).
  - B/BU select byte addr[1:0] (00 = bits 7:0).
  - Signed ops sign-extend; U ops zero-extend.
- Store, no fault:
  - W writes wd.
  - H/HU write wd[15:0] into the selected half.
  - B/BU write wd[7:0] into the selected byte.
  - Unselected bytes keep their old value (read-modify-write within the commit edge).
  - rd=0 and exc=0.
  - Log line on the commit edge: $display("@%h: *%h <= %h", pc, word-aligned byte address, full merged word).
- Inputs other than req are don't-care outside the accept edge. Latched values are held until commit.
- rvalid with we=1 still pulses so the stall logic can release the stage.
- No write-to-read forwarding is needed: only one request is ever outstanding.

Test Plan:
- Reset, DEPTH_LOG2=4 → ready=0 for 16 edges then 1; load W at each of the 16 words returns 0, exc=0.
- LATENCY=1:
  - sw 0x12345678 at BASE+8, then lw BASE+8 → rvalid one edge after each accept, rd=0x12345678.
  - Exactly one log line "@<pc>: *00000008 <= 12345678".
- Sub-word store then loads: word at BASE+4 holds 0x11223344; sb 0x80 at BASE+7 → word 0x80223344.
  - lb BASE+7 → 0xFFFFFF80.
  - lbu → 0x00000080.
  - lh BASE+6 → 0xFFFF8022.
  - lhu → 0x00008022.
- Faults:
  - lw BASE+2 → exc=1, rd=0.
  - sh BASE+1 → exc=1, word unchanged, no log line.
  - lw BASE+4·DEPTH → exc=1.
  - op=111 → exc=1.
- LATENCY=3:
  - accept at edge E → ready=0 at E+1..E+2, rvalid=1 only in the cycle after E+3.
  - req held high → next accept at E+4.
- Reset asserted mid-BUSY on a pending sw → outputs clear immediately without waiting for clk; store never lands (word reads 0 after the sweep); no log line.

Source files
------------

// File: rtl/dm_latency.sv
// Data memory for the MIPS datapath: configurable depth, base and latency,
// valid/ready handshake, sub-word loads/stores, fault reporting, reset sweep.
module dm_latency #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [31:0] pc,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rd,
   output logic        exc
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {INIT, IDLE, BUSY} state_t;
   typedef enum logic [2:0] {
      OP_W  = 3'b000,
      OP_HU = 3'b001,
      OP_H  = 3'b010,
      OP_BU = 3'b011,
      OP_B  = 3'b100
   } op_t;

   state_t                state, state_nx;
   logic [DEPTH_LOG2-1:0] idx, idx_nx;
   logic [3:0]            cnt, cnt_nx;
   logic                  accept, commit;

   logic                  we_q;
   logic [2:0]            op_q;
   logic [31:0]           addr_q, wd_q, pc_q;

   logic [31:0]           mem [DEPTH];

   logic [32:0]           off;
   logic [DEPTH_LOG2-1:0] widx;
   logic                  fault;
   logic [31:0]           old_w, new_w, load_w, wd_rep;
   logic [15:0]           half;
   logic [7:0]            byte_s;
   logic [3:0]            be;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
      end
   end

   // Every accept goes through BUSY so the commit edge is always E+LATENCY.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      accept   = 1'b0;
      commit   = 1'b0;
      case (state)
         INIT: begin
            idx_nx = idx + DEPTH_LOG2'(1);
            if (&idx) state_nx = IDLE;
         end
         IDLE: begin
            if (req) begin
               accept   = 1'b1;
               cnt_nx   = 4'(LATENCY - 1);
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               commit   = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: state_nx = INIT;
      endcase
   end

   assign ready = (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q   <= 1'b0;
         op_q   <= '0;
         addr_q <= '0;
         wd_q   <= '0;
         pc_q   <= '0;
      end else if (accept) begin
         we_q   <= we;
         op_q   <= op;
         addr_q <= addr;
         wd_q   <= wd;
         pc_q   <= pc;
      end
   end

   // Offset is computed with a borrow bit: any set bit above the word index
   // means the address is below BASE or past the end of the array.
   always_comb begin
      off   = {1'b0, addr_q} - {1'b0, BASE};
      widx  = off[DEPTH_LOG2+1:2];
      old_w = mem[widx];
      fault = (off[32:DEPTH_LOG2+2] != '0);
      case (op_q)
         OP_W:        fault = fault | (addr_q[1:0] != 2'b00);
         OP_H, OP_HU: fault = fault | addr_q[0];
         OP_B, OP_BU: fault = fault;
         default:     fault = 1'b1;
      endcase
   end

   always_comb begin
      half = addr_q[1] ? old_w[31:16] : old_w[15:0];
      case (addr_q[1:0])
         2'b00:   byte_s = old_w[7:0];
         2'b01:   byte_s = old_w[15:8];
         2'b10:   byte_s = old_w[23:16];
         default: byte_s = old_w[31:24];
      endcase
      load_w = '0;
      be     = 4'b0000;
      wd_rep = wd_q;
      case (op_q)
         OP_W: begin
            load_w = old_w;
            be     = 4'b1111;
         end
         OP_HU, OP_H: begin
            load_w = (op_q == OP_H) ? {{16{half[15]}}, half} : {16'h0000, half};
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{wd_q[15:0]}};
         end
         OP_BU, OP_B: begin
            load_w = (op_q == OP_B) ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            be     = 4'b0001 << addr_q[1:0];
            wd_rep = {4{wd_q[7:0]}};
         end
         default: begin
            load_w = '0;
            be     = 4'b0000;
         end
      endcase
      for (int unsigned i = 0; i < 4; i++) begin
         new_w[8*i +: 8] = be[i] ? wd_rep[8*i +: 8] : old_w[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid <= 1'b0;
         rd     <= '0;
         exc    <= 1'b0;
      end else begin
         rvalid <= commit;
         rd     <= (commit && !we_q && !fault) ? load_w : '0;
         exc    <= commit && fault;
      end
   end

   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[idx] <= '0;
      end else if (commit && we_q && !fault) begin
         mem[widx] <= new_w;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && commit && we_q && !fault) begin
         $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, new_w);
      end
   end
`endif

endmodule

// File: tb/tb_dm_latency.sv
// Directed bench for dm_latency: one LATENCY=1 instance at BASE 0 and one
// LATENCY=3 instance at BASE 0x100, both 16 words deep.
module tb_dm_latency;

   logic        clk = 1'b0;
   logic        rst1, req1, we1, ready1, rvalid1, exc1;
   logic        rst3, req3, we3, ready3, rvalid3, exc3;
   logic [2:0]  op1, op3;
   logic [31:0] addr1, wd1, pc1, rd1;
   logic [31:0] addr3, wd3, pc3, rd3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_latency #(.DEPTH_LOG2(4), .BASE(32'h0000_0000), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(rst1), .req(req1), .we(we1), .op(op1), .addr(addr1),
      .wd(wd1), .pc(pc1), .ready(ready1), .rvalid(rvalid1), .rd(rd1), .exc(exc1)
   );

   dm_latency #(.DEPTH_LOG2(4), .BASE(32'h0000_0100), .LATENCY(3)) u_lat3 (
      .clk(clk), .reset(rst3), .req(req3), .we(we3), .op(op3), .addr(addr3),
      .wd(wd3), .pc(pc3), .ready(ready3), .rvalid(rvalid3), .rd(rd3), .exc(exc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on instance s (0 = LATENCY 1, 1 = LATENCY 3); returns response.
   task automatic acc(input bit s, input logic w, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                      output logic [31:0] r, output logic x);
      int n;
      n = 0;
      while (!(s ? ready3 : ready1) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (s) begin
         req3 = 1'b1; we3 = w; op3 = o; addr3 = a; wd3 = d; pc3 = p;
      end else begin
         req1 = 1'b1; we1 = w; op1 = o; addr1 = a; wd1 = d; pc1 = p;
      end
      @(posedge clk); #1;
      req1 = 1'b0;
      req3 = 1'b0;
      n = 0;
      while (!(s ? rvalid3 : rvalid1) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check(s ? "latency3" : "latency1", 32'(n), s ? 32'd3 : 32'd1);
      r = s ? rd3 : rd1;
      x = s ? exc3 : exc1;
   endtask

   task automatic sweep_wait(input bit s);
      int n;
      n = 0;
      while (!(s ? ready3 : ready1) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check(s ? "sweep3_edges" : "sweep1_edges", 32'(n), 32'd16);
   endtask

   logic [31:0] r;
   logic        x;

   initial begin
      rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; op1 = '0; addr1 = '0; wd1 = '0; pc1 = '0;
      rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; op3 = '0; addr3 = '0; wd3 = '0; pc3 = '0;
      #12;
      check("rst_ready1", {31'b0, ready1}, 32'd0);
      check("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_exc1", {31'b0, exc1}, 32'd0);
      check("rst_ready3", {31'b0, ready3}, 32'd0);
      rst1 = 1'b0;
      rst3 = 1'b0;
      sweep_wait(1'b0);
      check("sweep3_ready", {31'b0, ready3}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         acc(1'b0, 1'b0, 3'b000, 32'(i * 4), '0, '0, r, x);
         check("swept_word", r, 32'h0);
         check("swept_exc", {31'b0, x}, 32'd0);
      end

      acc(1'b0, 1'b1, 3'b000, 32'h8, 32'h1234_5678, 32'h0040_0010, r, x);
      check("sw_rd", r, 32'h0);
      check("sw_exc", {31'b0, x}, 32'd0);
      acc(1'b0, 1'b0, 3'b000, 32'h8, '0, '0, r, x);
      check("lw8", r, 32'h1234_5678);

      acc(1'b0, 1'b1, 3'b000, 32'h4, 32'h1122_3344, 32'h0040_0020, r, x);
      acc(1'b0, 1'b1, 3'b100, 32'h7, 32'h0000_0080, 32'h0040_0024, r, x);
      check("sb_exc", {31'b0, x}, 32'd0);
      acc(1'b0, 1'b0, 3'b000, 32'h4, '0, '0, r, x);
      check("lw4_merged", r, 32'h8022_3344);
      acc(1'b0, 1'b0, 3'b100, 32'h7, '0, '0, r, x);
      check("lb7", r, 32'hFFFF_FF80);
      acc(1'b0, 1'b0, 3'b011, 32'h7, '0, '0, r, x);
      check("lbu7", r, 32'h0000_0080);
      acc(1'b0, 1'b0, 3'b010, 32'h6, '0, '0, r, x);
      check("lh6", r, 32'hFFFF_8022);
      acc(1'b0, 1'b0, 3'b001, 32'h6, '0, '0, r, x);
      check("lhu6", r, 32'h0000_8022);
      acc(1'b0, 1'b0, 3'b011, 32'h5, '0, '0, r, x);
      check("lbu5", r, 32'h0000_0033);
      acc(1'b0, 1'b0, 3'b100, 32'h4, '0, '0, r, x);
      check("lb4", r, 32'h0000_0044);
      acc(1'b0, 1'b1, 3'b010, 32'h4, 32'hAAAA_BEEF, 32'h0040_0030, r, x);
      acc(1'b0, 1'b0, 3'b000, 32'h4, '0, '0, r, x);
      check("sh4_merged", r, 32'h8022_BEEF);

      acc(1'b0, 1'b0, 3'b000, 32'h2, '0, '0, r, x);
      check("lw2_exc", {31'b0, x}, 32'd1);
      check("lw2_rd", r, 32'h0);
      acc(1'b0, 1'b1, 3'b010, 32'h5, 32'h0000_5555, 32'h0040_0040, r, x);
      check("sh5_exc", {31'b0, x}, 32'd1);
      acc(1'b0, 1'b0, 3'b000, 32'h4, '0, '0, r, x);
      check("sh5_unchanged", r, 32'h8022_BEEF);
      acc(1'b0, 1'b0, 3'b000, 32'h40, '0, '0, r, x);
      check("lw_end_exc", {31'b0, x}, 32'd1);
      acc(1'b0, 1'b0, 3'b111, 32'h0, '0, '0, r, x);
      check("op111_exc", {31'b0, x}, 32'd1);
      acc(1'b0, 1'b0, 3'b000, 32'h3C, '0, '0, r, x);
      check("lw_last_exc", {31'b0, x}, 32'd0);

      acc(1'b0, 1'b0, 3'b000, 32'h8, '0, '0, r, x);
      #1 rst1 = 1'b1;
      #1;
      check("async_rvalid1", {31'b0, rvalid1}, 32'd0);
      check("async_rd1", rd1, 32'h0);
      check("async_ready1", {31'b0, ready1}, 32'd0);
      rst1 = 1'b0;

      acc(1'b1, 1'b0, 3'b000, 32'hFC, '0, '0, r, x);
      check("below_base_exc", {31'b0, x}, 32'd1);
      acc(1'b1, 1'b1, 3'b000, 32'h104, 32'hCAFE_F00D, 32'h0040_0100, r, x);
      acc(1'b1, 1'b0, 3'b000, 32'h104, '0, '0, r, x);
      check("lat3_lw", r, 32'hCAFE_F00D);

      req3 = 1'b1; we3 = 1'b0; op3 = 3'b000; addr3 = 32'h104;
      @(posedge clk); #1;
      check("e0_ready", {31'b0, ready3}, 32'd0);
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk); #1;
         check("busy_ready", {31'b0, ready3}, 32'd0);
         check("busy_rvalid", {31'b0, rvalid3}, 32'd0);
      end
      @(posedge clk); #1;
      check("e3_rvalid", {31'b0, rvalid3}, 32'd1);
      check("e3_ready", {31'b0, ready3}, 32'd1);
      check("e3_rd", rd3, 32'hCAFE_F00D);
      @(posedge clk); #1;
      check("e4_rvalid", {31'b0, rvalid3}, 32'd0);
      check("e4_reaccept", {31'b0, ready3}, 32'd0);
      req3 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("e7_rvalid", {31'b0, rvalid3}, 32'd1);

      req3 = 1'b1; we3 = 1'b1; op3 = 3'b000; addr3 = 32'h108; wd3 = 32'hDEAD_BEEF; pc3 = 32'h0040_0200;
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk); #2;
      rst3 = 1'b1;
      #1;
      check("midbusy_ready", {31'b0, ready3}, 32'd0);
      check("midbusy_rvalid", {31'b0, rvalid3}, 32'd0);
      check("midbusy_exc", {31'b0, exc3}, 32'd0);
      #1 rst3 = 1'b0;
      sweep_wait(1'b1);
      acc(1'b1, 1'b0, 3'b000, 32'h108, '0, '0, r, x);
      check("dropped_store", r, 32'h0);
      acc(1'b1, 1'b0, 3'b000, 32'h104, '0, '0, r, x);
      check("resweep_word", r, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
